// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM arbiter: owner tags for the
// two-stage access pipeline, default address width, streak counter width.
package sram_arb_pkg;

    localparam int SRAM_AW  = 14;
    localparam int STREAK_W = 4;

    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_CPU_RD = 2'd1,
        OWN_CPU_WR = 2'd2,
        OWN_VID_RD = 2'd3
    } owner_e;

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational grant selection: video wins unless the CPU has waited
// VID_MAX_STREAK consecutive video grants.
module sram_arb_pick
    import sram_arb_pkg::*;
#(
    parameter int VID_MAX_STREAK = 4
) (
    input  logic                reset,
    input  logic                cpu_req,
    input  logic                vid_req,
    input  logic [STREAK_W-1:0] streak,
    output logic                cpu_gnt,
    output logic                vid_gnt,
    output logic [STREAK_W-1:0] streak_nxt
);

    localparam logic [STREAK_W-1:0] MAX_STREAK = STREAK_W'(VID_MAX_STREAK);

    always_comb begin
        cpu_gnt    = 1'b0;
        vid_gnt    = 1'b0;
        streak_nxt = '0;
        if (!reset) begin
            if (vid_req && !(cpu_req && streak >= MAX_STREAK))
                vid_gnt = 1'b1;
            else if (cpu_req)
                cpu_gnt = 1'b1;
        end
        // Only a video grant that leaves the CPU waiting extends the streak.
        if (vid_gnt && cpu_req)
            streak_nxt = (streak >= MAX_STREAK) ? MAX_STREAK : streak + 1'b1;
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester arbiter for the external async SRAM: grant, registered
// address/write stage, then read-data return stage tagged by owner.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int AW             = SRAM_AW,
    parameter int VID_MAX_STREAK = 4
) (
    input  logic          clk_core,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [15:0]   cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [15:0]   cpu_rdata,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_gnt,
    output logic          vid_rvalid,
    output logic [15:0]   vid_rdata,
    output logic [AW-1:0] sram_a,
    output logic          sram_wr,
    output logic [15:0]   host_to_sram,
    input  logic [15:0]   sram_to_host
);

    logic [STREAK_W-1:0] streak, streak_nxt;
    owner_e              owner1, owner1_nxt;

    sram_arb_pick #(.VID_MAX_STREAK(VID_MAX_STREAK)) u_pick (
        .reset      (reset),
        .cpu_req    (cpu_req),
        .vid_req    (vid_req),
        .streak     (streak),
        .cpu_gnt    (cpu_gnt),
        .vid_gnt    (vid_gnt),
        .streak_nxt (streak_nxt)
    );

    always_comb begin
        owner1_nxt = OWN_NONE;
        if (vid_gnt)
            owner1_nxt = OWN_VID_RD;
        else if (cpu_gnt)
            owner1_nxt = cpu_we ? OWN_CPU_WR : OWN_CPU_RD;
    end

    always_ff @(posedge clk_core) begin
        if (reset) begin
            streak       <= '0;
            owner1       <= OWN_NONE;
            sram_a       <= '0;
            sram_wr      <= 1'b0;
            host_to_sram <= '0;
            cpu_rvalid   <= 1'b0;
            vid_rvalid   <= 1'b0;
            cpu_rdata    <= '0;
            vid_rdata    <= '0;
        end else begin
            streak  <= streak_nxt;
            owner1  <= owner1_nxt;
            sram_wr <= cpu_gnt & cpu_we;
            // Address holds when idle so the pads see no toggling.
            if (vid_gnt)
                sram_a <= vid_addr;
            else if (cpu_gnt)
                sram_a <= cpu_addr;
            if (cpu_gnt && cpu_we)
                host_to_sram <= cpu_wdata;

            cpu_rvalid <= (owner1 == OWN_CPU_RD);
            vid_rvalid <= (owner1 == OWN_VID_RD);
            if (owner1 == OWN_CPU_RD)
                cpu_rdata <= sram_to_host;
            if (owner1 == OWN_VID_RD)
                vid_rdata <= sram_to_host;
        end
    end

endmodule
